// File: rtl/spm_loader_pkg.sv
// Shared defaults and state encoding for the SPM program loader.
package spm_loader_pkg;

  localparam int         WORD_SIZE_DEF = 8;
  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_COUNT = 3'd2,
    ST_DATA  = 3'd3,
    ST_CSUM  = 3'd4,
    ST_RUN   = 3'd5,
    ST_ERR   = 3'd6
  } state_t;

endpackage

// File: rtl/spm_csum_acc.sv
// Modular frame-checksum accumulator; sum_zero tells whether adding din would land on zero.
module spm_csum_acc #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         add,
  input  logic [W-1:0] din,
  output logic [W-1:0] sum,
  output logic         sum_zero
);

  logic [W-1:0] sum_next;

  assign sum_next = sum + din;
  assign sum_zero = (sum_next == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum <= '0;
    end else if (clr) begin
      sum <= '0;
    end else if (add) begin
      sum <= sum_next;
    end
  end

endmodule

// File: rtl/spm_program_loader.sv
// Host-link loader: parses SYNC/addr/count/data/checksum frames into SPM external writes
// and holds the CPU in reset until a frame with a good checksum has been written.
//
// state | meaning
// IDLE  | waiting for SYNC, everything else dropped
// ADDR  | next byte is the start address
// COUNT | next byte is the payload length (0 = full memory depth)
// DATA  | payload bytes, one memory write each
// CSUM  | checksum byte; good -> RUN, bad -> ERR
// RUN   | CPU released; SYNC restarts a load
// ERR   | bad checksum seen; CPU held, load_err set until SYNC
module spm_program_loader
  import spm_loader_pkg::*;
#(
  parameter int                   word_size    = WORD_SIZE_DEF,
  parameter logic [word_size-1:0] SYNC_BYTE    = SYNC_BYTE_DEF,
  parameter bit                   RUN_ON_RESET = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [word_size-1:0] in_data,
  output logic                 in_ready,
  output logic                 ext_write,
  output logic [word_size-1:0] address_bus,
  output logic [word_size-1:0] data_bus,
  output logic                 cpu_rst_n,
  output logic                 load_done,
  output logic                 load_err
);

  state_t               state_q, state_d;
  logic [word_size-1:0] ptr_q, ptr_d;
  logic [word_size:0]   rem_q, rem_d;
  logic                 ready_q;
  logic                 wr_d;
  logic [word_size-1:0] addr_d, data_d;
  logic                 cpu_d, done_d, err_d;
  logic                 sum_clr, sum_add, sum_zero;
  logic [word_size-1:0] sum_cur;
  logic                 xfer;

  assign in_ready = ready_q;
  assign xfer     = in_valid & ready_q;

  spm_csum_acc #(.W(word_size)) u_csum (
    .clk      (clk),
    .rst      (rst),
    .clr      (sum_clr),
    .add      (sum_add),
    .din      (in_data),
    .sum      (sum_cur),
    .sum_zero (sum_zero)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      rem_q       <= '0;
      ready_q     <= 1'b0;
      ext_write   <= 1'b0;
      address_bus <= '0;
      data_bus    <= '0;
      cpu_rst_n   <= RUN_ON_RESET;
      load_done   <= 1'b0;
      load_err    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      rem_q       <= rem_d;
      ready_q     <= 1'b1;
      ext_write   <= wr_d;
      address_bus <= addr_d;
      data_bus    <= data_d;
      cpu_rst_n   <= cpu_d;
      load_done   <= done_d;
      load_err    <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    wr_d    = 1'b0;
    addr_d  = address_bus;
    data_d  = data_bus;
    cpu_d   = cpu_rst_n;
    done_d  = 1'b0;
    err_d   = load_err;
    sum_clr = 1'b0;
    sum_add = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_RUN, ST_ERR: begin
        if (xfer && (in_data == SYNC_BYTE)) begin
          state_d = ST_ADDR;
          cpu_d   = 1'b0;
          err_d   = 1'b0;
          sum_clr = 1'b1;
        end
      end
      ST_ADDR: begin
        if (xfer) begin
          ptr_d   = in_data;
          sum_add = 1'b1;
          state_d = ST_COUNT;
        end
      end
      ST_COUNT: begin
        if (xfer) begin
          // A zero count loads the whole memory, hence the extra bit on rem.
          rem_d   = (in_data == '0) ? {1'b1, {word_size{1'b0}}} : {1'b0, in_data};
          sum_add = 1'b1;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (xfer) begin
          wr_d    = 1'b1;
          addr_d  = ptr_q;
          data_d  = in_data;
          ptr_d   = ptr_q + 1'b1;
          rem_d   = rem_q - 1'b1;
          sum_add = 1'b1;
          if (rem_q == {{word_size{1'b0}}, 1'b1}) begin
            state_d = ST_CSUM;
          end
        end
      end
      ST_CSUM: begin
        if (xfer) begin
          if (sum_zero) begin
            state_d = ST_RUN;
            cpu_d   = 1'b1;
            done_d  = 1'b1;
          end else begin
            state_d = ST_ERR;
            err_d   = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_spm_program_loader.sv
// Directed bench for spm_program_loader with a write scoreboard on the memory port.
module tb_spm_program_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       ext_write;
  logic [7:0] address_bus;
  logic [7:0] data_bus;
  logic       cpu_rst_n;
  logic       load_done;
  logic       load_err;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int wr_cnt = 0;
  int first_wr = -1;
  int last_wr = -1;
  int done_cnt = 0;
  logic [15:0] exp_q[$];

  spm_program_loader dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .ext_write   (ext_write),
    .address_bus (address_bus),
    .data_bus    (data_bus),
    .cpu_rst_n   (cpu_rst_n),
    .load_done   (load_done),
    .load_err    (load_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Memory-port monitor: every write must match the next expected {addr,data}.
  always @(negedge clk) begin
    logic [15:0] e;
    if (rst === 1'b1) begin
      if (load_done === 1'b1) done_cnt++;
      if (ext_write === 1'b1) begin
        wr_cnt++;
        if (first_wr < 0) first_wr = cyc;
        last_wr = cyc;
        if (exp_q.size() == 0) begin
          chk("unexpected_write", {31'd0, ext_write}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", {24'd0, address_bus}, {24'd0, e[15:8]});
          chk("wr_data", {24'd0, data_bus}, {24'd0, e[7:0]});
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    in_valid = 1'b1;
    in_data  = b;
    t = 0;
    while (in_ready !== 1'b1 && t < 20) begin
      step();
      t++;
    end
    chk("in_ready", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    repeat (gap) step();
  endtask

  function automatic int pick_gap(input int gap_max);
    return (gap_max == 0) ? 0 : int'($urandom_range(gap_max, 1));
  endfunction

  task automatic send_frame(input logic [7:0] addr, input int n, input bit good,
                            input int gap_max, input bit rnd, input bit b2b);
    logic [7:0] sum, a, d, csum;
    int w0, d0;
    w0 = wr_cnt;
    d0 = done_cnt;
    first_wr = -1;
    send_byte(8'hA5, pick_gap(gap_max));
    chk("sync_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
    chk("sync_load_err", {31'd0, load_err}, 32'd0);
    sum = addr;
    send_byte(addr, pick_gap(gap_max));
    sum = sum + 8'(n);
    send_byte(8'(n), pick_gap(gap_max));
    a = addr;
    for (int i = 0; i < n; i++) begin
      d = rnd ? 8'($urandom) : 8'(8'h11 * (i + 1));
      exp_q.push_back({a, d});
      sum = sum + d;
      a = a + 8'd1;
      send_byte(d, pick_gap(gap_max));
    end
    csum = good ? (8'h00 - sum) : (8'h01 - sum);
    send_byte(csum, 0);
    chk("done_pulse", {31'd0, load_done}, {31'd0, good});
    chk("cpu_rst_n_after", {31'd0, cpu_rst_n}, {31'd0, good});
    chk("load_err_after", {31'd0, load_err}, {31'd0, !good});
    chk("writes_drained", exp_q.size(), 32'd0);
    chk("write_count", wr_cnt - w0, n);
    if (b2b) chk("b2b_span", last_wr - first_wr, n - 1);
    step();
    chk("done_one_cycle", {31'd0, load_done}, 32'd0);
    chk("done_count", done_cnt - d0, {31'd0, good});
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    chk({tag, "_ext_write"}, {31'd0, ext_write}, 32'd0);
    chk({tag, "_address_bus"}, {24'd0, address_bus}, 32'd0);
    chk({tag, "_data_bus"}, {24'd0, data_bus}, 32'd0);
    chk({tag, "_load_done"}, {31'd0, load_done}, 32'd0);
    chk({tag, "_load_err"}, {31'd0, load_err}, 32'd0);
    chk({tag, "_cpu_rst_n"}, {31'd0, cpu_rst_n}, 32'd0);
  endtask

  initial begin
    int w0;
    rst      = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) step();
    chk_reset_vals("reset");
    rst = 1'b1;
    step();
    chk("ready_after_reset", {31'd0, in_ready}, 32'd1);

    // A5,10,03,11,22,33,csum: back-to-back writes, CPU released
    send_frame(8'h10, 3, 1'b1, 0, 1'b0, 1'b1);

    // Bad checksum, then a good frame clears load_err
    send_frame(8'h10, 3, 1'b0, 0, 1'b0, 1'b1);
    step();
    chk("err_sticky", {31'd0, load_err}, 32'd1);
    chk("err_cpu_held", {31'd0, cpu_rst_n}, 32'd0);
    send_frame(8'h10, 3, 1'b1, 0, 1'b0, 1'b1);

    // Address wrap FE, FF, 00
    send_frame(8'hFE, 3, 1'b1, 0, 1'b1, 1'b1);

    // Gaps of 1-5 idle cycles between bytes
    send_frame(8'h40, 6, 1'b1, 5, 1'b1, 1'b0);

    // RUN: non-SYNC dropped, SYNC restarts
    send_byte(8'h5A, 1);
    chk("run_drop_cpu", {31'd0, cpu_rst_n}, 32'd1);
    send_frame(8'h20, 2, 1'b1, 0, 1'b1, 1'b1);

    // Count 0 means 256 bytes
    send_frame(8'h80, 256, 1'b1, 0, 1'b1, 1'b1);

    // Reset in the middle of DATA
    send_byte(8'hA5, 0);
    send_byte(8'h30, 0);
    send_byte(8'h05, 0);
    exp_q.push_back({8'h30, 8'h3C});
    send_byte(8'h3C, 0);
    exp_q.push_back({8'h31, 8'h7E});
    send_byte(8'h7E, 0);
    step();
    rst = 1'b0;
    #1;
    chk_reset_vals("mid_reset");
    w0 = wr_cnt;
    step();
    step();
    rst = 1'b1;
    repeat (10) step();
    chk("no_write_after_reset", wr_cnt - w0, 32'd0);
    chk("queue_after_reset", exp_q.size(), 32'd0);
    chk("cpu_held_after_reset", {31'd0, cpu_rst_n}, 32'd0);
    send_frame(8'h31, 4, 1'b1, 2, 1'b1, 1'b0);

    repeat (3) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
